exec_call_nn_sequencer: RTL and testbench
=========================================

EXEC_CALL_NN_SEQUENCER -- requirements
Module: exec_call_nn_sequencer

Interface
REQ-001 SHALL have port CLK, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-002 SHALL have port notRESET, input, 1 bit: the reset; asynchronous and active-low.
REQ-003 SHALL have port start, input, 1 bit: one-cycle CALL nn launch, driven from the decoder's P2_Set_ICALLnn_0 path.
REQ-004 SHALL have port cond_ok, input, 1 bit: call condition; tied to 1 for unconditional CALL nn; sampled only in RD_HI on ack.
REQ-005 SHALL have port pc_in, input, 16 bits: PC addressing the first operand byte; sampled on accepted start.
REQ-006 SHALL have port sp_in, input, 16 bits: current SP; sampled on accepted start.
REQ-007 SHALL have port mem_ack, input, 1 bit: bus completes the current request this cycle.
REQ-008 SHALL have port data_in, input, 8 bits: read data; valid with mem_ack during reads.
REQ-009 SHALL have port rd_req, output, 1 bit: memory read request.
REQ-010 SHALL have port wr_req, output, 1 bit: memory write request.
REQ-011 SHALL have port addr, output, 16 bits: bus address.
REQ-012 SHALL have port data_out, output, 8 bits: write data.
REQ-013 SHALL have port pc_load, output, 1 bit: strobe; PC takes pc_new.
REQ-014 SHALL have port pc_new, output, 16 bits: new PC value.
REQ-015 SHALL have port sp_load, output, 1 bit: strobe; SP takes sp_new.
REQ-016 SHALL have port sp_new, output, 16 bits: new SP value.
REQ-017 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-018 SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-019 SHALL implement the states IDLE, RD_LO, RD_HI, WR_H, WR_L and FINISH, with all outputs decoded from registered state.
REQ-020 In IDLE, start=1 SHALL latch pc_in into pc_r and sp_in into sp_r, then go to RD_LO; start SHALL be ignored in all other states.
REQ-021 RD_LO SHALL hold rd_req=1 and addr=pc_r until mem_ack; on mem_ack it SHALL latch nn_lo=data_in, set pc_r=pc_r+1 and go to RD_HI.
REQ-022 RD_HI SHALL behave as RD_LO but latch nn_hi=data_in, set pc_r=pc_r+1 (now the return address) and go to WR_H if cond_ok=1, otherwise to FINISH with taken=0.
REQ-023 WR_H SHALL hold wr_req=1, addr=sp_r-1 and data_out=pc_r[15:8] until mem_ack; on mem_ack it SHALL set sp_r=sp_r-1 and go to WR_L.
REQ-024 WR_L SHALL hold wr_req=1, addr=sp_r-1 and data_out=pc_r[7:0] until mem_ack; on mem_ack it SHALL set sp_r=sp_r-1, set taken=1 and go to FINISH.
REQ-025 FINISH SHALL, for exactly one cycle, assert done=1 and pc_load=1, then return to IDLE.
- taken=1: pc_new={nn_hi,nn_lo}, sp_load=1, sp_new=sp_r.
- taken=0: pc_new=pc_r, sp_load=0.
REQ-026 All address and pointer arithmetic SHALL be modulo 2^16.
- pc_in=FFFF: operands read from FFFF then 0000.
- sp_in=0000: writes to FFFF then FFFE, final SP FFFE.
REQ-027 rd_req and wr_req SHALL never be high together, and SHALL be low in IDLE and FINISH.
REQ-028 mem_ack SHALL be ignored in IDLE and FINISH.
REQ-029 Each request SHALL stay high with stable addr/data_out for any number of wait cycles until mem_ack.
REQ-030 Minimum latency with mem_ack held high: start at cycle t, then RD_LO t+1, RD_HI t+2, WR_H t+3, WR_L t+4, done at t+5, IDLE at t+6.
REQ-031 A not-taken call with mem_ack held high SHALL give done at t+3.

Reset
REQ-032 notRESET=0 SHALL immediately, without waiting for a clock edge, force IDLE.
- Outputs forced to 0: rd_req, wr_req, pc_load, sp_load, busy, done.
- Outputs forced to 0000/00: addr, data_out, pc_new, sp_new.
- Internal registers cleared: pc_r, sp_r, nn_lo, nn_hi, taken.
REQ-033 A reset during any state SHALL abort the call with no pc_load or sp_load, and the first start after reset release SHALL be accepted normally.

Verification
REQ-034 Taken call: pc_in=1234, sp_in=8000, cond_ok=1, reads 78 then 56, mem_ack always high -> reads at 1234/1235, writes 12@7FFF then 36@7FFE, done at t+5, pc_new=5678, sp_new=7FFE.
REQ-035 Not taken: same stimulus with cond_ok=0 -> no wr_req, done at t+3, pc_new=1236, sp_load=0.
REQ-036 Wrap: pc_in=FFFF, sp_in=0000 -> reads at FFFF/0000, writes 00@FFFF then 01@FFFE, sp_new=FFFE.
REQ-037 Wait states: mem_ack delayed 3 cycles per access -> request, addr and data stable throughout, done at t+17.
REQ-038 Start while busy: start pulsed in WR_H -> ignored, single done.
REQ-039 Reset mid-op: notRESET low in WR_L -> wr_req drops without a clock edge, no pc_load, next start completes normally.

Source files
------------

// File: rtl/exec_call_nn_sequencer.sv
// rtl/exec_call_nn_sequencer.sv - CALL nn bus sequencer: fetch nn, push return address, load PC/SP
//
// Purpose:
//   On a start pulse in IDLE, reads the two operand bytes of CALL nn at the
//   PC, and then tests the call condition. If the condition holds, it pushes
//   the return address high byte first and then finishes with a PC/SP load.
//   A not-taken call skips the pushes and loads the PC with the return address.
//
// Ports:
//   CLK, notRESET         clock, asynchronous active-low reset
//   start                 one-cycle launch, honoured only in IDLE
//   cond_ok               call condition, sampled on the RD_HI acknowledge
//   pc_in, sp_in          PC/SP captured on an accepted start
//   mem_ack, data_in      bus completion and read data
//   rd_req, wr_req        bus requests, held until mem_ack
//   addr, data_out        bus address and write data
//   pc_load, pc_new       PC update strobe and value
//   sp_load, sp_new       SP update strobe and value
//   busy, done            not-IDLE flag, one-cycle completion pulse
module exec_call_nn_sequencer (
   input  logic        CLK,
   input  logic        notRESET,
   input  logic        start,
   input  logic        cond_ok,
   input  logic [15:0] pc_in,
   input  logic [15:0] sp_in,
   input  logic        mem_ack,
   input  logic [7:0]  data_in,
   output logic        rd_req,
   output logic        wr_req,
   output logic [15:0] addr,
   output logic [7:0]  data_out,
   output logic        pc_load,
   output logic [15:0] pc_new,
   output logic        sp_load,
   output logic [15:0] sp_new,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RD_LO  = 3'd1,
      S_RD_HI  = 3'd2,
      S_WR_H   = 3'd3,
      S_WR_L   = 3'd4,
      S_FINISH = 3'd5
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] sp_q, sp_d;
   logic [7:0]  nn_lo_q, nn_lo_d;
   logic [7:0]  nn_hi_q, nn_hi_d;
   logic        taken_q, taken_d;

   // Pre-decrement push address; 16-bit wrap is the natural result.
   logic [15:0] sp_dec;
   assign sp_dec = sp_q - 16'd1;

   // State register
   always_ff @(posedge CLK or negedge notRESET) begin
      if (!notRESET) begin
         state_q <= S_IDLE;
         pc_q    <= 16'h0000;
         sp_q    <= 16'h0000;
         nn_lo_q <= 8'h00;
         nn_hi_q <= 8'h00;
         taken_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         sp_q    <= sp_d;
         nn_lo_q <= nn_lo_d;
         nn_hi_q <= nn_hi_d;
         taken_q <= taken_d;
      end
   end

   // Next-state and datapath updates
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      sp_d    = sp_q;
      nn_lo_d = nn_lo_q;
      nn_hi_d = nn_hi_q;
      taken_d = taken_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               pc_d    = pc_in;
               sp_d    = sp_in;
               taken_d = 1'b0;
               state_d = S_RD_LO;
            end
         end
         S_RD_LO: begin
            if (mem_ack) begin
               nn_lo_d = data_in;
               pc_d    = pc_q + 16'd1;
               state_d = S_RD_HI;
            end
         end
         S_RD_HI: begin
            // After this increment pc_q holds the return address.
            if (mem_ack) begin
               nn_hi_d = data_in;
               pc_d    = pc_q + 16'd1;
               if (cond_ok) begin
                  state_d = S_WR_H;
               end else begin
                  taken_d = 1'b0;
                  state_d = S_FINISH;
               end
            end
         end
         S_WR_H: begin
            if (mem_ack) begin
               sp_d    = sp_dec;
               state_d = S_WR_L;
            end
         end
         S_WR_L: begin
            if (mem_ack) begin
               sp_d    = sp_dec;
               taken_d = 1'b1;
               state_d = S_FINISH;
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Outputs, decoded from registered state only
   always_comb begin
      rd_req   = 1'b0;
      wr_req   = 1'b0;
      addr     = 16'h0000;
      data_out = 8'h00;
      pc_load  = 1'b0;
      pc_new   = 16'h0000;
      sp_load  = 1'b0;
      sp_new   = 16'h0000;
      busy     = (state_q != S_IDLE);
      done     = 1'b0;
      case (state_q)
         S_RD_LO, S_RD_HI: begin
            rd_req = 1'b1;
            addr   = pc_q;
         end
         S_WR_H: begin
            wr_req   = 1'b1;
            addr     = sp_dec;
            data_out = pc_q[15:8];
         end
         S_WR_L: begin
            wr_req   = 1'b1;
            addr     = sp_dec;
            data_out = pc_q[7:0];
         end
         S_FINISH: begin
            done    = 1'b1;
            pc_load = 1'b1;
            if (taken_q) begin
               pc_new  = {nn_hi_q, nn_lo_q};
               sp_load = 1'b1;
               sp_new  = sp_q;
            end else begin
               pc_new  = pc_q;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_exec_call_nn_sequencer.sv
// tb/tb_exec_call_nn_sequencer.sv - scoreboard bench for exec_call_nn_sequencer
module tb_exec_call_nn_sequencer;

   logic        CLK;
   logic        notRESET;
   logic        start;
   logic        cond_ok;
   logic [15:0] pc_in;
   logic [15:0] sp_in;
   logic        mem_ack;
   logic [7:0]  data_in;
   logic        rd_req;
   logic        wr_req;
   logic [15:0] addr;
   logic [7:0]  data_out;
   logic        pc_load;
   logic [15:0] pc_new;
   logic        sp_load;
   logic [15:0] sp_new;
   logic        busy;
   logic        done;

   exec_call_nn_sequencer dut (
      .CLK      (CLK),
      .notRESET (notRESET),
      .start    (start),
      .cond_ok  (cond_ok),
      .pc_in    (pc_in),
      .sp_in    (sp_in),
      .mem_ack  (mem_ack),
      .data_in  (data_in),
      .rd_req   (rd_req),
      .wr_req   (wr_req),
      .addr     (addr),
      .data_out (data_out),
      .pc_load  (pc_load),
      .pc_new   (pc_new),
      .sp_load  (sp_load),
      .sp_new   (sp_new),
      .busy     (busy),
      .done     (done)
   );

   typedef struct {
      bit          is_wr;
      logic [15:0] a;
      logic [7:0]  d;
   } bus_t;

   typedef struct {
      logic [15:0] pc_new;
      bit          sp_load;
      logic [15:0] sp_new;
      int          cyc;
   } done_t;

   bus_t  bus_q[$];
   done_t done_q[$];
   bus_t  mb;
   done_t md;

   logic [7:0] mem [0:65535];
   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int done_cnt = 0;
   int wait_mode = 0;
   int seen   = 0;
   int target = 0;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int pick_wait();
      if (wait_mode < 0) return $urandom_range(0, 3);
      return wait_mode;
   endfunction

   // Bus responder: acks each request after a chosen number of wait cycles,
   // and toggles mem_ack randomly while no request is up.
   initial begin
      mem_ack = 1'b0;
      data_in = 8'h00;
      forever begin
         @(posedge CLK);
         #1;
         if (!(rd_req || wr_req)) begin
            seen    = 0;
            target  = pick_wait();
            mem_ack = 1'($urandom_range(0, 1));
         end else begin
            if (mem_ack) begin
               seen   = 0;
               target = pick_wait();
            end
            mem_ack = (seen == target);
            seen++;
         end
         data_in = mem[addr];
      end
   end

   // Monitor: compares every bus cycle and every completion against the scoreboard.
   always @(negedge CLK) begin
      if (notRESET) begin
         chk("rd_wr_exclusive", {31'd0, rd_req & wr_req}, 32'd0);
         if (rd_req || wr_req) begin
            if (bus_q.size() == 0) begin
               chk("unexpected_req", {30'd0, rd_req, wr_req}, 32'd0);
            end else begin
               mb = bus_q[0];
               chk("req_kind", {30'd0, rd_req, wr_req}, mb.is_wr ? 32'd1 : 32'd2);
               chk("req_addr", {16'd0, addr}, {16'd0, mb.a});
               if (mb.is_wr) chk("wr_data", {24'd0, data_out}, {24'd0, mb.d});
               chk("busy_in_req", {31'd0, busy}, 32'd1);
               if (mem_ack) begin
                  if (wr_req) mem[addr] = data_out;
                  void'(bus_q.pop_front());
               end
            end
         end
         if (done || pc_load) begin
            done_cnt++;
            if (done_q.size() == 0) begin
               chk("unexpected_done", {30'd0, done, pc_load}, 32'd0);
            end else begin
               md = done_q.pop_front();
               chk("done_pc_load", {30'd0, done, pc_load}, 32'd3);
               chk("pc_new", {16'd0, pc_new}, {16'd0, md.pc_new});
               chk("sp_load", {31'd0, sp_load}, {31'd0, md.sp_load});
               if (md.sp_load) chk("sp_new", {16'd0, sp_new}, {16'd0, md.sp_new});
               if (md.cyc >= 0) chk("done_cycle", cyc, md.cyc);
               chk("bus_drained_at_done", bus_q.size(), 32'd0);
            end
         end else begin
            chk("sp_load_without_done", {31'd0, sp_load}, 32'd0);
         end
      end
   end

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ctl"}, {26'd0, rd_req, wr_req, pc_load, sp_load, busy, done}, 32'd0);
      chk({tag, "_addr"}, {16'd0, addr}, 32'd0);
      chk({tag, "_data_out"}, {24'd0, data_out}, 32'd0);
      chk({tag, "_pc_new"}, {16'd0, pc_new}, 32'd0);
      chk({tag, "_sp_new"}, {16'd0, sp_new}, 32'd0);
   endtask

   task automatic do_reset_pulse();
      @(posedge CLK);
      #2;
      notRESET = 1'b0;
      bus_q.delete();
      done_q.delete();
      @(negedge CLK);
      #1;
      notRESET = 1'b1;
   endtask

   // One CALL nn: expectations are derived from the memory image, then stimulus is driven.
   // extra: 0 none, 1 start pulse on a random busy cycle, 2 start pulse in WR_H.
   task automatic do_call(input logic [15:0] pc, input logic [15:0] sp, input bit cond,
                          input int extra, input bit rst_wrl);
      logic [15:0] ret;
      logic [15:0] pc1;
      bus_t        b;
      done_t       d;
      int          d0;
      int          lat;
      int          n;
      bit          got;
      ret = pc + 16'd2;
      pc1 = pc + 16'd1;
      b.is_wr = 1'b0; b.a = pc;  b.d = mem[pc];  bus_q.push_back(b);
      b.is_wr = 1'b0; b.a = pc1; b.d = mem[pc1]; bus_q.push_back(b);
      if (cond) begin
         b.is_wr = 1'b1; b.a = sp - 16'd1; b.d = ret[15:8]; bus_q.push_back(b);
         b.is_wr = 1'b1; b.a = sp - 16'd2; b.d = ret[7:0];  bus_q.push_back(b);
      end
      d.pc_new  = cond ? {mem[pc1], mem[pc]} : ret;
      d.sp_load = cond;
      d.sp_new  = sp - 16'd2;
      lat = (wait_mode >= 0) ? ((cond ? 4 : 2) * (wait_mode + 1) + 1) : -1;

      @(posedge CLK);
      #1;
      start   = 1'b1;
      pc_in   = pc;
      sp_in   = sp;
      cond_ok = cond;
      d.cyc   = (lat < 0) ? -1 : cyc + lat;
      done_q.push_back(d);
      d0 = done_cnt;
      @(posedge CLK);
      #1;
      start = 1'b0;
      pc_in = 16'($urandom);
      sp_in = 16'($urandom);

      if (rst_wrl) begin
         got = 1'b0;
         for (int i = 0; i < 200; i++) begin
            if (wr_req && addr == sp - 16'd2) begin
               got = 1'b1;
               break;
            end
            @(posedge CLK);
            #1;
         end
         chk("reach_wr_l", {31'd0, got}, 32'd1);
         #1;
         notRESET = 1'b0;
         bus_q.delete();
         done_q.delete();
         #1;
         chk_reset_outputs("abort");
         @(negedge CLK);
         #1;
         chk("abort_no_pc_load", {30'd0, pc_load, sp_load}, 32'd0);
         notRESET = 1'b1;
         repeat (2) @(posedge CLK);
         return;
      end

      if (extra == 1) begin
         n = $urandom_range(0, 3);
         repeat (n) begin
            @(posedge CLK);
            #1;
         end
         if (busy) begin
            start = 1'b1;
            pc_in = 16'($urandom);
            @(posedge CLK);
            #1;
            start = 1'b0;
         end
      end else if (extra == 2) begin
         got = 1'b0;
         for (int i = 0; i < 200; i++) begin
            if (wr_req && addr == sp - 16'd1) begin
               got = 1'b1;
               break;
            end
            @(posedge CLK);
            #1;
         end
         chk("reach_wr_h", {31'd0, got}, 32'd1);
         start = 1'b1;
         pc_in = 16'hBEEF;
         @(posedge CLK);
         #1;
         start = 1'b0;
      end

      got = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (done_cnt != d0) begin
            got = 1'b1;
            break;
         end
         @(posedge CLK);
      end
      chk("done_seen", {31'd0, got}, 32'd1);
      if (!got) do_reset_pulse();
      repeat (2) @(posedge CLK);
      #1;
      chk("idle_after_done", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      notRESET = 1'b0;
      start    = 1'b0;
      cond_ok  = 1'b1;
      pc_in    = 16'h0000;
      sp_in    = 16'h0000;
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      #1;
      chk_reset_outputs("reset");
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk_reset_outputs("reset_clocked");
      notRESET = 1'b1;

      wait_mode = 0;
      mem[16'h1234] = 8'h78;
      mem[16'h1235] = 8'h56;
      do_call(16'h1234, 16'h8000, 1'b1, 0, 1'b0);
      do_call(16'h1234, 16'h8000, 1'b0, 0, 1'b0);
      do_call(16'hFFFF, 16'h0000, 1'b1, 0, 1'b0);
      chk("wrap_push_hi", {24'd0, mem[16'hFFFF]}, 32'h00);
      chk("wrap_push_lo", {24'd0, mem[16'hFFFE]}, 32'h01);
      wait_mode = 3;
      do_call(16'h1234, 16'h8000, 1'b1, 0, 1'b0);
      wait_mode = 1;
      do_call(16'h4000, 16'hC000, 1'b1, 2, 1'b0);
      wait_mode = 2;
      do_call(16'h2222, 16'h9000, 1'b1, 0, 1'b1);
      wait_mode = 0;
      do_call(16'h1234, 16'h8000, 1'b1, 0, 1'b0);

      for (int k = 0; k < 40; k++) begin
         wait_mode = int'($urandom_range(0, 4)) - 1;
         do_call(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 1)), 1'b0);
      end

      chk("bus_q_empty", bus_q.size(), 32'd0);
      chk("done_q_empty", done_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
